// File: rtl/gym_pkg.sv
// Shared types and limits for the gym scene: movement directions, screen
// extents and the move-controller state encoding.
package gym_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_MOVE  = 2'd2
  } move_state_e;

  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_MAX = 10'd479;

  // True when one more pixel in dir would leave the visible screen.
  function automatic logic leaves_screen(input dir_e dir, input logic [9:0] x,
                                         input logic [9:0] y);
    logic hit;
    hit = 1'b0;
    case (dir)
      DIR_DOWN:  hit = (y == Y_MAX);
      DIR_UP:    hit = (y == 10'd0);
      DIR_LEFT:  hit = (x == 10'd0);
      DIR_RIGHT: hit = (x == X_MAX);
      default:   hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gym_move_controller_if.sv
// Signal bundle between the gym scene top level and the move controller,
// including the query/answer pair for the external bounds checker.
interface gym_move_controller_if;
  logic       frame_tick;
  logic       gym_active;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       at_bounds;
  logic [1:0] query_dir;
  logic [9:0] charxcurrpos;
  logic [9:0] charycurrpos;
  logic [1:0] facing;
  logic       moving;
  logic [1:0] walk_frame;
  logic       step_done;
  logic       bump;

  modport master (
    output frame_tick, gym_active, key_valid, key_dir, at_bounds,
    input  query_dir, charxcurrpos, charycurrpos, facing, moving,
           walk_frame, step_done, bump
  );

  modport slave (
    input  frame_tick, gym_active, key_valid, key_dir, at_bounds,
    output query_dir, charxcurrpos, charycurrpos, facing, moving,
           walk_frame, step_done, bump
  );
endinterface

// File: rtl/gym_step_counter.sv
// Pixel counter for one tile step: clear on entry, count moved pixels and
// flag the increment that completes the tile.
module gym_step_counter #(
  parameter logic [4:0] STEP_PIXELS = 5'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic       terminal,
  output logic [1:0] frame_idx
);

  logic [4:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Set while the next increment lands exactly on the tile size.
  assign terminal  = ((cnt_q + 5'd1) == STEP_PIXELS);
  assign frame_idx = cnt_q[3:2];

endmodule

// File: rtl/gym_move_controller.sv
// Tile-step movement controller for the gym character: accepts a direction
// on a frame tick, asks the bounds checker, then walks one pixel per frame.
module gym_move_controller
  import gym_pkg::*;
#(
  parameter logic [9:0] START_X     = 10'd240,
  parameter logic [9:0] START_Y     = 10'd340,
  parameter logic [4:0] STEP_PIXELS = 5'd16
) (
  input logic                 Clk,
  input logic                 Reset_n,
  gym_move_controller_if.slave bus
);

  move_state_e state_q, state_d;
  dir_e        dir_q, dir_d;
  dir_e        facing_q, facing_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        step_done_q, step_done_d;
  logic        bump_q, bump_d;

  logic        cnt_clear;
  logic        cnt_inc;
  logic        cnt_terminal;
  logic [1:0]  cnt_frame;
  logic        blocked;

  gym_step_counter #(
    .STEP_PIXELS(STEP_PIXELS)
  ) u_step_counter (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .terminal (cnt_terminal),
    .frame_idx(cnt_frame)
  );

  // Screen edges count as walls so positions saturate instead of wrapping.
  assign blocked = bus.at_bounds | leaves_screen(dir_q, x_q, y_q);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    facing_d    = facing_q;
    x_d         = x_q;
    y_d         = y_q;
    step_done_d = 1'b0;
    bump_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;

    if (!bus.gym_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_tick && bus.key_valid) begin
            dir_d    = dir_e'(bus.key_dir);
            facing_d = dir_e'(bus.key_dir);
            state_d  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (blocked) begin
            bump_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_clear = 1'b1;
            state_d   = ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (bus.frame_tick) begin
            if (blocked) begin
              bump_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              case (dir_q)
                DIR_DOWN:  y_d = y_q + 10'd1;
                DIR_UP:    y_d = y_q - 10'd1;
                DIR_LEFT:  x_d = x_q - 10'd1;
                default:   x_d = x_q + 10'd1;
              endcase
              cnt_inc = 1'b1;
              if (cnt_terminal) begin
                step_done_d = 1'b1;
                state_d     = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: only control/datapath flops exist here, so every one takes the async reset value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_DOWN;
      facing_q    <= DIR_DOWN;
      x_q         <= START_X;
      y_q         <= START_Y;
      step_done_q <= 1'b0;
      bump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      facing_q    <= facing_d;
      x_q         <= x_d;
      y_q         <= y_d;
      step_done_q <= step_done_d;
      bump_q      <= bump_d;
    end
  end

  assign bus.query_dir    = (state_q == ST_IDLE) ? bus.key_dir : dir_q;
  assign bus.charxcurrpos = x_q;
  assign bus.charycurrpos = y_q;
  assign bus.facing       = facing_q;
  assign bus.moving       = (state_q == ST_MOVE);
  assign bus.walk_frame   = (state_q == ST_MOVE) ? cnt_frame : 2'd0;
  assign bus.step_done    = step_done_q;
  assign bus.bump         = bump_q;

endmodule
